// File: rtl/sbox_stream.sv
// sbox_stream: time-multiplexed DES S-box stage, LANES lookups per cycle over 8/LANES passes
// Ports: clk, rst_n (async active-low); flush (sync abort, highest priority);
//        in_valid/in_ready/in_data[47:0] (round-key XOR result, S1 in [47:42]);
//        out_valid/out_ready/out_data[31:0] ({S1..S8}, S1 in [31:28]); busy (BUSY state)
module sbox_stream #(
  parameter int LANES = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        flush,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [47:0] in_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data,
  output logic        busy
);
  localparam int PASSES = 8 / LANES;
  localparam int PW = PASSES > 1 ? $clog2(PASSES) : 1;
  if (LANES != 1 && LANES != 2 && LANES != 4 && LANES != 8) begin : g_bad_lanes
    $error("sbox_stream: LANES must be 1, 2, 4 or 8");
  end
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  state_t state_q, state_d;
  logic [PW-1:0] pass_q, pass_d;
  logic [47:0] hold_q, hold_d;
  logic [31:0] res_q, res_d;
  logic [2:0] idx [LANES];
  logic [3:0] lane_out [LANES];
  logic accept, last;
  for (genvar l = 0; l < LANES; l++) begin : g_lane
    assign idx[l] = 3'(int'(pass_q) * LANES + l);
    SBox u_sbox (
      .s_in   (hold_q[6*(7-idx[l]) +: 6]),
      .box_num(idx[l]),
      .s_out  (lane_out[l])
    );
  end
  assign in_ready  = state_q == IDLE || (state_q == DONE && out_ready);
  assign accept    = in_valid && in_ready && !flush;
  assign last      = pass_q == PW'(PASSES - 1);
  assign out_valid = state_q == DONE;
  assign busy      = state_q == BUSY;
  assign out_data  = res_q;
  always_comb begin
    state_d = flush ? IDLE : accept ? BUSY : (state_q == BUSY && last) ? DONE :
              (state_q == DONE && out_ready) ? IDLE : state_q;
    pass_d  = (flush || accept) ? '0 : (state_q == BUSY && !last) ? pass_q + 1'b1 : pass_q;
    hold_d  = accept ? in_data : hold_q;
    res_d   = res_q;
    if (state_q == BUSY)
      for (int j = 0; j < LANES; j++) res_d[4*(7-idx[j]) +: 4] = lane_out[j];
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      pass_q  <= '0;
      hold_q  <= '0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      pass_q  <= pass_d;
      hold_q  <= hold_d;
      res_q   <= res_d;
    end
  end
endmodule

// SBox: DES S-box lookup; row = {s_in[5], s_in[0]}, column = s_in[4:1], box_num 0 = S1
module SBox (
  input  logic [5:0] s_in,
  input  logic [2:0] box_num,
  output logic [3:0] s_out
);
  localparam logic [2047:0] SBOX_ROM = {
    64'hE4D12FB83A6C5907, 64'h0F74E2D1A6CB9538, 64'h41E8D62BFC973A50, 64'hFC8249175B3EA06D,
    64'hF18E6B34972DC05A, 64'h3D47F28EC01A69B5, 64'h0E7BA4D158C6932F, 64'hD8A13F42B67C05E9,
    64'hA09E63F51DC7B428, 64'hD709346A285ECBF1, 64'hD6498F30B12C5AE7, 64'h1AD069874FE3B52C,
    64'h7DE3069A1285BC4F, 64'hD8B56F03472C1AE9, 64'hA690CB7DF13E5284, 64'h3F06A1D8945BC72E,
    64'h2C417AB6853FD0E9, 64'hEB2C47D150FA3986, 64'h421BAD78F9C5630E, 64'hB8C71E2D6F09A453,
    64'hC1AF92680D34E75B, 64'hAF427C9561DE0B38, 64'h9EF528C3704A1DB6, 64'h432C95FABE17608D,
    64'h4B2EF08D3C975A61, 64'hD0B7491AE35C2F86, 64'h14BDC37EAF680592, 64'h6BD814A7950FE23C,
    64'hD2846FB1A93E50C7, 64'h1FD8A374C56B0E92, 64'h7B419CE206ADF358, 64'h21E74A8DFC90356B
  };
  logic [8:0] idx;
  assign idx   = {box_num, s_in[5], s_in[0], s_in[4:1]};
  assign s_out = SBOX_ROM[{~idx, 2'b00} +: 4];
endmodule
